// File: rtl/write_reg_scoreboard_pkg.sv
// write_reg_scoreboard_pkg: shared write-back types and scoreboard entry layout.
package write_reg_scoreboard_pkg;
   localparam int SB_CNT_W = 2;
   typedef logic [4:0] creg_addr_t;
   typedef logic [SB_CNT_W-1:0] cnt_t;
   typedef enum logic [1:0] {SRC_NOP = 2'd0, SRC_ALU = 2'd1, SRC_MEM = 2'd2} src_t;
   typedef struct packed {
      logic       valid;
      src_t       src;
      logic [31:0] value;
      creg_addr_t dst;
   } write_reg_t;
   typedef struct packed {
      cnt_t cnt;
      src_t last_src;
   } sb_entry_t;
endpackage

// File: rtl/write_reg_scoreboard_sb_lane_hazard.sv
// write_reg_scoreboard_sb_lane_hazard: busy/load-use lookup for one lane, bypassing
// older accepted writes of the same issue group.
module write_reg_scoreboard_sb_lane_hazard
   import write_reg_scoreboard_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int NUM_REGS  = 32,
   parameter int LANE      = 0
) (
   input  sb_entry_t [NUM_REGS-1:0]  i_sb,
   input  logic [NUM_LANES-1:0]      i_acc,
   input  creg_addr_t [NUM_LANES-1:0] i_dst,
   input  src_t [NUM_LANES-1:0]      i_src,
   input  creg_addr_t                i_rs,
   input  creg_addr_t                i_rt,
   output logic                      o_rs_busy,
   output logic                      o_rt_busy,
   output logic                      o_load_use
);
   logic w_rs_byp, w_rt_byp, w_unused;
   src_t w_rs_src, w_rt_src;
   assign w_unused = ^{i_acc, i_dst, i_src};
   always_comb begin
      w_rs_byp = 1'b0;
      w_rt_byp = 1'b0;
      w_rs_src = i_sb[i_rs].last_src;
      w_rt_src = i_sb[i_rt].last_src;
      // later lanes overwrite, so the youngest older writer wins
      for (int j = 0; j < LANE; j++) begin
         if (i_acc[j] && i_dst[j] == i_rs) begin
            w_rs_byp = 1'b1;
            w_rs_src = i_src[j];
         end
         if (i_acc[j] && i_dst[j] == i_rt) begin
            w_rt_byp = 1'b1;
            w_rt_src = i_src[j];
         end
      end
      o_rs_busy  = (i_rs != '0) && (w_rs_byp || i_sb[i_rs].cnt != '0);
      o_rt_busy  = (i_rt != '0) && (w_rt_byp || i_sb[i_rt].cnt != '0);
      o_load_use = (o_rs_busy && w_rs_src == SRC_MEM) || (o_rt_busy && w_rt_src == SRC_MEM);
   end
endmodule

// File: rtl/write_reg_scoreboard.sv
// write_reg_scoreboard: counts in-flight GPR writes per register from issue to commit
// and exports per-lane busy/load-use hazards. CNT_W must equal SB_CNT_W.
module write_reg_scoreboard
   import write_reg_scoreboard_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int NUM_REGS  = 32,
   parameter int CNT_W     = SB_CNT_W
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_flush,
   input  logic [NUM_LANES-1:0]        i_issue_valid,
   input  write_reg_t [NUM_LANES-1:0]  i_issue_wr,
   output logic [NUM_LANES-1:0]        o_issue_ready,
   input  creg_addr_t [NUM_LANES-1:0]  i_query_rs,
   input  creg_addr_t [NUM_LANES-1:0]  i_query_rt,
   output logic [NUM_LANES-1:0]        o_rs_busy,
   output logic [NUM_LANES-1:0]        o_rt_busy,
   output logic [NUM_LANES-1:0]        o_load_use,
   input  logic [NUM_LANES-1:0]        i_commit_valid,
   input  creg_addr_t [NUM_LANES-1:0]  i_commit_dst,
   output logic [CNT_W+4:0]            o_inflight,
   output logic                        o_err_underflow
);
   localparam int LIM = (1 << CNT_W) - 1;
   sb_entry_t [NUM_REGS-1:0] r_sb, w_nxt;
   logic [CNT_W+4:0] r_inflight, w_sum;
   logic r_err, w_uf, w_ok, w_unused;
   logic [NUM_LANES-1:0] w_wr, w_acc;
   creg_addr_t [NUM_LANES-1:0] w_dst;
   src_t [NUM_LANES-1:0] w_lsrc;
   int w_need, w_add, w_sub;
   src_t w_src;
   always_comb begin
      w_unused = 1'b0;
      for (int k = 0; k < NUM_LANES; k++) w_unused = w_unused ^ (^i_issue_wr[k].value);
   end
   // in-order acceptance: a lane fits only if its whole older same-dst group fits
   always_comb begin
      w_ok = 1'b1;
      w_wr = '0;
      w_acc = '0;
      w_need = 0;
      o_issue_ready = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         w_wr[k] = i_issue_valid[k] && i_issue_wr[k].valid && (i_issue_wr[k].dst != '0);
         w_need = int'(r_sb[i_issue_wr[k].dst].cnt) + 1;
         for (int j = 0; j < k; j++)
            w_need = w_need + ((w_acc[j] && i_issue_wr[j].dst == i_issue_wr[k].dst) ? 1 : 0);
         w_ok = w_ok && (!w_wr[k] || w_need <= LIM);
         o_issue_ready[k] = w_ok;
         w_acc[k] = w_ok && w_wr[k];
      end
   end
   always_comb begin
      w_nxt = r_sb;
      w_uf = 1'b0;
      w_sum = '0;
      w_add = 0;
      w_sub = 0;
      w_src = SRC_NOP;
      for (int r = 0; r < NUM_REGS; r++) begin
         w_add = 0;
         w_sub = 0;
         w_src = r_sb[r].last_src;
         for (int k = 0; k < NUM_LANES; k++) begin
            if (w_acc[k] && int'(i_issue_wr[k].dst) == r) begin
               w_add = w_add + 1;
               w_src = i_issue_wr[k].src;
            end
            if (i_commit_valid[k] && i_commit_dst[k] != '0 && int'(i_commit_dst[k]) == r)
               w_sub = w_sub + 1;
         end
         w_uf = w_uf || (int'(r_sb[r].cnt) < w_sub);
         w_nxt[r].cnt = (int'(r_sb[r].cnt) < w_sub) ? '0 : cnt_t'(int'(r_sb[r].cnt) + w_add - w_sub);
         w_nxt[r].last_src = w_src;
         w_sum = w_sum + (CNT_W+5)'(w_nxt[r].cnt);
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_sb <= '0;
         r_inflight <= '0;
      end else begin
         r_sb <= w_nxt;
         r_inflight <= w_sum;
      end
      if (i_reset) r_err <= 1'b0;
      else if (!i_flush && w_uf) r_err <= 1'b1;
   end
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign w_dst[g] = i_issue_wr[g].dst;
      assign w_lsrc[g] = i_issue_wr[g].src;
      write_reg_scoreboard_sb_lane_hazard #(
         .NUM_LANES(NUM_LANES), .NUM_REGS(NUM_REGS), .LANE(g)
      ) u_hz (
         .i_sb(r_sb), .i_acc(w_acc), .i_dst(w_dst), .i_src(w_lsrc),
         .i_rs(i_query_rs[g]), .i_rt(i_query_rt[g]),
         .o_rs_busy(o_rs_busy[g]), .o_rt_busy(o_rt_busy[g]), .o_load_use(o_load_use[g])
      );
   end
   assign o_inflight = r_inflight;
   assign o_err_underflow = r_err;
endmodule

// File: doc/write_reg_scoreboard.md
Name: write_reg_scoreboard

Overview:
- Multi-lane successor to the single-lane write-back decode.
- Takes the already-decoded write_reg_t of up to NUM_LANES instructions per cycle.
- Tracks in-flight writes per architectural GPR (count plus last producer source) until commit.
- Exports busy/load-use hazard flags for issue-stage stall and forwarding control.
- Sits between decode and issue; commit feedback comes from the write-back stage.

Parameters:
- NUM_LANES, 2, issue lanes and commit lanes per cycle (1..4).
- NUM_REGS, 32, architectural registers; reg 0 is never tracked.
- CNT_W, 2, per-register in-flight counter width; saturation limit is 2^CNT_W-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; discards all in-flight state.
- issue_valid  in  NUM_LANES  lane k holds an instruction offered for issue.
- issue_wr  in  NUM_LANES x $bits(write_reg_t)  decoded write_reg (valid, src, value, dst) per lane.
- issue_ready  out  NUM_LANES  lane k accepted this cycle.
- query_rs, query_rt  in  NUM_LANES x 5  source registers read by lane k.
- rs_busy, rt_busy  out  NUM_LANES  a source has an older uncommitted writer.
- load_use  out  NUM_LANES  a busy source's youngest writer has src==SRC_MEM.
- commit_valid  in  NUM_LANES  write-back retiring a write.
- commit_dst  in  NUM_LANES x 5  register retired by commit lane k.
- inflight  out  CNT_W+5  total tracked in-flight writes.
- err_underflow  out  1  sticky; set when a commit hits a zero counter.

Behaviour:
- State per reg r (1..NUM_REGS-1): cnt[r] (CNT_W bits) and last_src[r] (src_t).
- Reset: all cnt=0, last_src=SRC_NOP, err_underflow=0.
- Reset: issue_ready=all 1 when issue_valid allows; outputs are combinational from state.
- A lane "writes" iff issue_valid[k] && issue_wr[k].valid && issue_wr[k].dst!=0.
  - Lanes with valid=0 or dst=0 are always ready and never tracked.
- Acceptance is in-order:
  - Lane k is ready iff lane k-1 is ready (lane 0 has no predecessor) and its dst counter plus all same-dst writes from accepted lanes <k stays <= saturation limit.
  - Once a lane is refused, all younger lanes are refused.
- Query, combinational, same cycle:
  - Lane k source s is busy if cnt[s]>0 or any accepted lane j<k writes s this cycle.
  - s==0 is never busy.
  - Producer for load_use is the youngest such writer: same-cycle lane j<k with the highest j first, else last_src[s].
- Next state per reg: cnt' = cnt + (#accepted writes to r) - (#commits to r).
  - Simultaneous issue and commit of the same reg nets out in one cycle.
  - last_src' = src of the youngest accepted writer of r this cycle, else unchanged.
- Commit to r with cnt[r] < #commits to r:
  - clamp cnt to 0 and set err_underflow.
  - Commit to dst 0 is ignored.
- flush: next cycle all cnt=0 and last_src=SRC_NOP.
  - flush has priority over same-cycle issue and commit.
  - issue_ready is still computed combinationally, but accepted writes are discarded.
  - err_underflow is unaffected; only reset clears it.
- inflight = sum of cnt, registered.
- Latency: issue visible in cnt the next cycle; same-cycle visibility only via intra-group bypass.
- reset mid-operation: state cleared next edge regardless of flush, issue or commit.

Decomposition:
- Shared package (mycpu.svh) holds:
  - write_reg_t and src_t (SRC_NOP/SRC_ALU/SRC_MEM), reused unchanged.
  - creg_addr_t.
  - a new typedef sb_entry_t {cnt, last_src}.
- One sub-module: sb_lane_hazard, the per-lane combinational busy/load_use lookup with intra-group bypass, instantiated NUM_LANES times.

Test Plan:
- Reset, then lane0 LW dst=5 (SRC_MEM), next cycle query rs=5 -> rs_busy=1, load_use=1; commit 5 -> following cycle rs_busy=0.
- Same cycle: lane0 ADDU dst=3, lane1 query rt=3 -> rt_busy[1]=1, load_use[1]=0 (bypass, SRC_ALU); lane0 query rt=3 -> 0.
- CNT_W=2: issue dst=7 three times, then issue dst=7 with an unrelated lane1 -> issue_ready=00, cnt[7] stays 3; commit one -> ready next cycle.
- Lane0 dst=0 and lane1 dst=9 -> both ready, only reg 9 tracked, inflight=1.
- cnt[4]=1 with issue dst=4 and commit dst=4 same cycle -> cnt[4]=1; commit dst=4 twice more -> cnt=0, err_underflow=1 (sticky).
- inflight=3, then flush together with issue dst=2 -> next cycle inflight=0, all busy flags 0.
